// File: rtl/clap_detector.sv
// Double-clap detector: magnitude/threshold on AXI-Stream ADC samples, then a
// clap-gap-clap sequencer toggling the light. Optional debug ports: CLAP_DETECTOR_DEBUG_EN.
module clap_detector #(
  parameter int unsigned SAMPLE_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH      = 12,
  parameter int unsigned MIDPOINT        = 2048,
  parameter int unsigned THRESHOLD       = 1024,
  parameter int unsigned HOLDOFF_SAMPLES = 2000,
  parameter int unsigned WINDOW_SAMPLES  = 16000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    axis_slave_valid,
  output logic                    axis_slave_ready,
  input  logic [SAMPLE_WIDTH-1:0] axis_slave_data,
  output logic                    clap_pulse,
  output logic                    light
`ifdef CLAP_DETECTOR_DEBUG_EN
  ,
  output logic [1:0]              debug_state,
  output logic [DATA_WIDTH-1:0]   debug_peak
`endif
);

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned CNT_W = clogb2(WINDOW_SAMPLES + 1);

  localparam logic [DATA_WIDTH-1:0] MID_C      = DATA_WIDTH'(MIDPOINT);
  localparam logic [DATA_WIDTH-1:0] THR_C      = DATA_WIDTH'(THRESHOLD);
  localparam logic [CNT_W-1:0]      HOLD_END_C = CNT_W'(HOLDOFF_SAMPLES - 1);
  localparam logic [CNT_W-1:0]      WIN_END_C  = CNT_W'(WINDOW_SAMPLES - 1);

  typedef enum logic [1:0] {
    WAIT_FIRST  = 2'd0,
    HOLDOFF1    = 2'd1,
    WAIT_SECOND = 2'd2,
    HOLDOFF2    = 2'd3
  } state_e;

  logic                  ready_q;
  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] mag_q;
  logic                  loud_q;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pulse_q, pulse_d;
  logic                  light_q, light_d;

  logic                  accept;
  logic [DATA_WIDTH-1:0] sample;
  logic [DATA_WIDTH-1:0] mag_d;
  logic [CNT_W-1:0]      cnt_inc;

  // Upper stream bits carry no data.
  if (SAMPLE_WIDTH > DATA_WIDTH) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^axis_slave_data[SAMPLE_WIDTH-1:DATA_WIDTH];
  end

  assign accept  = axis_slave_valid && ready_q;
  assign sample  = axis_slave_data[DATA_WIDTH-1:0];
  assign mag_d   = (sample >= MID_C) ? (sample - MID_C) : (MID_C - sample);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Stage 1: capture magnitude and loudness of the accepted sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      mag_q      <= '0;
      loud_q     <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      s1_valid_q <= accept;
      if (accept) begin
        mag_q  <= mag_d;
        loud_q <= (mag_d >= THR_C);
      end
    end
  end

  // Stage 2: sequencer state, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= WAIT_FIRST;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      light_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      light_q <= light_d;
    end
  end

  // The counter tracks the index of the current sample relative to the last clap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    light_d = light_q;
    if (s1_valid_q) begin
      case (state_q)
        WAIT_FIRST: begin
          if (loud_q) begin
            pulse_d = 1'b1;
            cnt_d   = '0;
            state_d = HOLDOFF1;
          end
        end
        HOLDOFF1: begin
          cnt_d = cnt_inc;
          if (cnt_inc == HOLD_END_C) begin
            state_d = WAIT_SECOND;
          end
        end
        WAIT_SECOND: begin
          if (loud_q) begin
            pulse_d = 1'b1;
            light_d = ~light_q;
            cnt_d   = '0;
            state_d = HOLDOFF2;
          end else if (cnt_inc == WIN_END_C) begin
            cnt_d   = '0;
            state_d = WAIT_FIRST;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HOLDOFF2: begin
          if (cnt_inc == HOLD_END_C) begin
            cnt_d   = '0;
            state_d = WAIT_FIRST;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = WAIT_FIRST;
        end
      endcase
    end
  end

  assign axis_slave_ready = ready_q;
  assign clap_pulse       = pulse_q;
  assign light            = light_q;

`ifdef CLAP_DETECTOR_DEBUG_EN
  logic [DATA_WIDTH-1:0] peak_q;

  // Running maximum magnitude since reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      peak_q <= '0;
    end else if (s1_valid_q && (mag_q > peak_q)) begin
      peak_q <= mag_q;
    end
  end

  assign debug_state = state_q;
  assign debug_peak  = peak_q;
`endif

endmodule

// File: tb/tb_clap_detector.sv
// Bench for clap_detector: directed clap patterns plus random traffic,
// checked against an index-based reference model of the clap rules.
module tb_clap_detector;

  localparam int MID  = 2048;
  localparam int THR  = 1024;
  localparam int HOLD = 2000;
  localparam int WIN  = 16000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] data  = 16'd0;
  logic        ready, pulse, light;
`ifdef CLAP_DETECTOR_DEBUG_EN
  logic [1:0]  dbg_state;
  logic [11:0] dbg_peak;
`endif

  clap_detector dut (
    .clock            (clock),
    .reset            (reset),
    .axis_slave_valid (valid),
    .axis_slave_ready (ready),
    .axis_slave_data  (data),
    .clap_pulse       (pulse),
    .light            (light)
`ifdef CLAP_DETECTOR_DEBUG_EN
    ,
    .debug_state      (dbg_state),
    .debug_peak       (dbg_peak)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: positions are sample indices since reset.
  int m_mode;    // 0 idle, 1 after first clap, 2 after second clap
  int m_first;
  int m_second;
  int m_idx;
  int m_peak;
  bit m_light;

  bit          pend_v;
  logic [15:0] pend_d;
  bit          last_acc;
  int          n_pulse;

  int          ev_idx[$];
  logic [15:0] ev_dat[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_sample(input logic [15:0] w, output bit p);
    int d;
    int mag;
    bit loud;
    d    = int'(w[11:0]);
    mag  = (d >= MID) ? d - MID : MID - d;
    loud = (mag >= THR);
    p    = 1'b0;
    if (mag > m_peak) m_peak = mag;
    if (m_mode == 2 && (m_idx - m_second) >= HOLD) m_mode = 0;
    if (m_mode == 0) begin
      if (loud) begin
        p       = 1'b1;
        m_first = m_idx;
        m_mode  = 1;
      end
    end else if (m_mode == 1) begin
      if ((m_idx - m_first) >= HOLD) begin
        if (loud) begin
          p        = 1'b1;
          m_light  = ~m_light;
          m_second = m_idx;
          m_mode   = 2;
        end else if ((m_idx - m_first) == WIN - 1) begin
          m_mode = 0;
        end
      end
    end
    m_idx++;
  endtask

  task automatic step(input bit vin, input logic [15:0] din);
    bit acc;
    bit p;
    valid = vin;
    data  = din;
    acc   = vin && (ready === 1'b1);
    @(posedge clock);
    #1;
    p = 1'b0;
    if (pend_v) model_sample(pend_d, p);
    check_eq("clap_pulse", 32'(pulse), 32'(p));
    check_eq("light", 32'(light), 32'(m_light));
    if (pulse === 1'b1) n_pulse++;
    pend_v   = acc;
    pend_d   = din;
    last_acc = acc;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
      check_eq("ready_in_reset", 32'(ready), 32'd0);
      check_eq("pulse_in_reset", 32'(pulse), 32'd0);
      check_eq("light_in_reset", 32'(light), 32'd0);
    end
    reset    = 1'b0;
    m_mode   = 0;
    m_light  = 1'b0;
    m_idx    = 0;
    m_peak   = 0;
    pend_v   = 1'b0;
    n_pulse  = 0;
    step(1'b0, 16'd0);
    check_eq("ready_after_reset", 32'(ready), 32'd1);
  endtask

  // Stream n accepted samples of quiet level with the queued events inserted.
  task automatic play(input int n);
    int cnt;
    int guard;
    logic [15:0] d;
    cnt   = 0;
    guard = 0;
    while (cnt < n && guard < n + 16) begin
      d = 16'd2048;
      foreach (ev_idx[k]) if (ev_idx[k] == cnt) d = ev_dat[k];
      step(1'b1, d);
      if (last_acc) cnt++;
      guard++;
    end
    check_eq("accepted_count", 32'(cnt), 32'(n));
    step(1'b0, 16'd0);
    ev_idx.delete();
    ev_dat.delete();
  endtask

  task automatic add_ev(input int idx, input logic [15:0] d);
    ev_idx.push_back(idx);
    ev_dat.push_back(d);
  endtask

  initial begin
    logic [15:0] w;
    int          noise;
    bit          vin;

    do_reset(2);
    play(100);
    check_eq("quiet_pulses", 32'(n_pulse), 32'd0);
    check_eq("quiet_light", 32'(light), 32'd0);

    do_reset(1);
    add_ev(0, 16'd3500);
    add_ev(5000, 16'd3500);
    play(5100);
    check_eq("pair_pulses", 32'(n_pulse), 32'd2);
    check_eq("pair_light", 32'(light), 32'd1);

    do_reset(1);
    add_ev(0, 16'd3500);
    add_ev(17000, 16'd3500);
    add_ev(20000, 16'd3500);
    play(20100);
    check_eq("timeout_pulses", 32'(n_pulse), 32'd3);
    check_eq("timeout_light", 32'(light), 32'd1);

    do_reset(1);
    add_ev(0, 16'd3500);
    add_ev(1000, 16'd3500);
    add_ev(3000, 16'd3500);
    play(3100);
    check_eq("holdoff_pulses", 32'(n_pulse), 32'd2);
    check_eq("holdoff_light", 32'(light), 32'd1);

    do_reset(1);
    add_ev(0, 16'd3071);
    add_ev(1, 16'd3072);
    add_ev(2501, 16'd1100);
    add_ev(3001, 16'd500);
    play(3100);
    check_eq("thresh_pulses", 32'(n_pulse), 32'd2);
    check_eq("thresh_light", 32'(light), 32'd1);
`ifdef CLAP_DETECTOR_DEBUG_EN
    check_eq("thresh_peak", 32'(dbg_peak), 32'd1548);
`endif

    do_reset(1);
    add_ev(0, 16'd3500);
    add_ev(2500, 16'd3500);
    add_ev(5000, 16'd0);
    play(8000);
    check_eq("pre_reset_light", 32'(light), 32'd1);
`ifdef CLAP_DETECTOR_DEBUG_EN
    check_eq("pre_reset_state", 32'(dbg_state), 32'd2);
`endif
    do_reset(1);
`ifdef CLAP_DETECTOR_DEBUG_EN
    check_eq("post_reset_state", 32'(dbg_state), 32'd0);
`endif
    add_ev(10, 16'd4095);
    play(3000);
    check_eq("post_reset_pulses", 32'(n_pulse), 32'd1);
    check_eq("post_reset_light", 32'(light), 32'd0);

    // Random traffic: gapped valid, noisy quiet level, junk upper bits, sparse claps.
    do_reset(1);
    for (int i = 0; i < 20000; i++) begin
      if (i == 10000) do_reset(1);
      vin = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 799) == 0) begin
        w[11:0] = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(3072, 4095))
                                               : 12'($urandom_range(0, 1024));
      end else begin
        noise   = int'($urandom_range(0, 2000)) - 1000;
        w[11:0] = 12'(MID + noise);
      end
      w[15:12] = 4'($urandom_range(0, 15));
      step(vin, w);
    end
    step(1'b0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clap_detector.md
Name: clap_detector

Overview:
- Downstream consumer of the SPI ADC sampler's AXI-Stream master output.
- Converts each microphone sample to magnitude about the ADC midpoint and thresholds it to detect claps.
- Sequences a "clap, gap, clap" pattern and toggles the light output on each valid double clap.
- Sits between the SPI sampler and the board LED/relay driver.

Parameters:
- SAMPLE_WIDTH, 16, width of incoming stream word; only the low DATA_WIDTH bits carry data.
- DATA_WIDTH, 12, ADC resolution; sample is unsigned.
- MIDPOINT, 2048, quiet-level (DC) code.
- THRESHOLD, 1024, a magnitude >= THRESHOLD is "loud".
- HOLDOFF_SAMPLES, 2000, accepted samples ignored after each detected clap (debounce/ring-down).
- WINDOW_SAMPLES, 16000, maximum samples from first clap to second clap; must exceed HOLDOFF_SAMPLES.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- axis_slave_valid  input  1  sample valid from upstream.
- axis_slave_ready  output  1  block can accept a sample.
- axis_slave_data  input  SAMPLE_WIDTH  sample word; bits above DATA_WIDTH are ignored.
- clap_pulse  output  1  one-cycle pulse per detected (non-ignored) clap.
- light  output  1  light state; toggles on each double clap.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: axis_slave_ready=0 while reset is high, 1 from the first cycle after reset; clap_pulse=0; light=0; state=WAIT_FIRST; counter=0; pipeline valid flag=0.
- Handshake: a sample is accepted on any edge with valid&&ready. There is no backpressure outside reset. Data not accepted is never read.
- Stage 1, on the acceptance edge: mag = (d>=MIDPOINT) ? d-MIDPOINT : MIDPOINT-d, where d is the low DATA_WIDTH bits. mag is registered at DATA_WIDTH bits with no overflow, and loud = mag>=THRESHOLD. Stage-1 valid flag is set.
- Stage 2, on the edge after acceptance: the FSM and counter update. clap_pulse and light change on that edge, so latency from acceptance to output is 2 edges.
- Counter width is clogb2(WINDOW_SAMPLES+1). It advances only on stage-2-valid cycles, never on idle clocks.
- WAIT_FIRST:
  - loud -> clap_pulse=1, counter=0, go to HOLDOFF1.
  - otherwise stay.
- HOLDOFF1:
  - counter++; loudness is ignored.
  - when the counter reaches HOLDOFF_SAMPLES-1 -> WAIT_SECOND.
  - the counter keeps running, so the window is measured from the first clap.
- WAIT_SECOND:
  - loud -> clap_pulse=1, light toggles, counter=0, go to HOLDOFF2.
  - else if counter==WINDOW_SAMPLES-1 -> WAIT_FIRST, counter=0 (timeout, no toggle).
  - else counter++.
  - A loud sample on the timeout sample itself counts as the second clap.
- HOLDOFF2:
  - counter++; loudness is ignored.
  - at HOLDOFF_SAMPLES-1 -> WAIT_FIRST, counter=0.
  - This prevents a third clap from pairing immediately.
- clap_pulse is high for exactly one cycle; consecutive samples can never produce back-to-back pulses because of holdoff.
- Reset mid-operation: any in-flight sample is discarded, state returns to WAIT_FIRST, and light clears to 0.
- Input 0 gives mag=MIDPOINT; input 4095 gives mag=2047. Both are legal.

Optional Feature:
- Macro: CLAP_DETECTOR_DEBUG_EN.
- Defined: adds output ports debug_state (2 bits: WAIT_FIRST=0, HOLDOFF1=1, WAIT_SECOND=2, HOLDOFF2=3) and debug_peak (DATA_WIDTH bits).
  - debug_peak holds the maximum stage-1 mag seen since reset, updated on the stage-2 edge; reset value 0.
- Undefined: these ports and the peak register do not exist; all other behaviour is identical.

Test Plan:
- Reset, then 100 samples of 2048 with valid held high -> ready=1 after reset, clap_pulse never asserts, light=0.
- Sample 3500 (mag 1452) at index 0, 2048 otherwise, 3500 again at index 5000 -> clap_pulse at indices 0 and 5000 (2 edges after acceptance); light becomes 1 two edges after index 5000 is accepted.
- Claps at index 0 and index 17000 -> first pair times out at index 15999, light stays 0, the index-17000 clap is a new first clap; a further clap at 20000 sets light=1.
- Claps at indices 0, 1000 and 3000 -> index 1000 is ignored (no pulse); index 3000 toggles light to 1.
- Threshold boundary: first clap 3072 (mag 1024, loud), second 1100 (mag 948, quiet) then 500 (mag 1548, loud) -> exactly one toggle, on the 500 sample; with DEBUG_EN, debug_peak=1548.
- Assert reset for 1 cycle while in WAIT_SECOND with light=1 -> light=0 and state WAIT_FIRST; a single subsequent clap gives one clap_pulse and no toggle.
